// File: rtl/tdc_uart_readout.sv
// TDC readout: edge-captures measurement words into a small FIFO and streams them
// as 8N1 UART frames (sync byte 8'hA5 followed by the word, MSB byte first).
module tdc_uart_readout #(
  parameter int DATA_W     = 32,
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic [DATA_W-1:0]             iData,
  input  logic                          iDone,
  output logic                          oTx,
  output logic                          oBusy,
  output logic                          oOverflow,
  output logic [$clog2(FIFO_DEPTH):0]   oLevel
);

  localparam int NB = (DATA_W + 7) / 8;
  localparam int FW = (NB + 1) * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(NB + 1);

  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic              done_q_r;
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic              overflow_r;
  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [2:0]        bit_r;
  logic [BW-1:0]     byte_r;
  logic [FW-1:0]     frame_r;
  logic              tx_r;
  logic              busy_r;

  logic              push_s;
  logic              empty_s;
  logic              full_s;
  logic              baud_end_s;
  logic              frame_end_s;
  logic              pop_s;
  logic              accept_s;
  logic              drop_s;
  logic [NB*8-1:0]   word_ext_s;
  logic [FW-1:0]     load_frame_s;
  logic [7:0]        cur_byte_s;

  assign push_s       = iDone & ~done_q_r;
  assign empty_s      = (level_r == '0);
  assign full_s       = (level_r == DEPTH_L);
  assign baud_end_s   = (cnt_r == DIV_LAST);
  assign frame_end_s  = (state_r == ST_STOP) & baud_end_s & (byte_r == LAST_BYTE);
  assign pop_s        = ~empty_s & ((state_r == ST_IDLE) | frame_end_s);
  // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
  assign accept_s     = push_s & (~full_s | pop_s);
  assign drop_s       = push_s & full_s & ~pop_s;
  assign load_frame_s = {SYNC_BYTE, word_ext_s};
  assign cur_byte_s   = frame_r[FW-1 -: 8];

  // Zero-extend the FIFO head word to a whole number of bytes.
  always_comb begin
    word_ext_s              = '0;
    word_ext_s[DATA_W-1:0]  = mem_r[rd_ptr_r];
  end

  // Previous iDone for rising-edge detection.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      done_q_r <= 1'b0;
    end else begin
      done_q_r <= iDone;
    end
  end

  // Word buffer with occupancy count and sticky drop flag.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      overflow_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (accept_s) begin
        mem_r[wr_ptr_r] <= iData;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Serializer FSM; tx and busy are registered from the current state so they move together.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      bit_r   <= 3'd0;
      byte_r  <= '0;
      frame_r <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      busy_r <= (state_r != ST_IDLE) | ~empty_s;
      case (state_r)
        ST_IDLE: begin
          tx_r  <= 1'b1;
          cnt_r <= '0;
          if (pop_s) begin
            frame_r <= load_frame_s;
            byte_r  <= '0;
            state_r <= ST_START;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          tx_r <= 1'b0;
          if (baud_end_s) begin
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            state_r <= ST_DATA;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DATA: begin
          tx_r <= cur_byte_s[bit_r];
          if (baud_end_s) begin
            cnt_r <= '0;
            if (bit_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_r <= bit_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_STOP: begin
          tx_r <= 1'b1;
          if (baud_end_s) begin
            cnt_r <= '0;
            if (byte_r != LAST_BYTE) begin
              byte_r  <= byte_r + BW'(1);
              frame_r <= {frame_r[FW-9:0], 8'h00};
              state_r <= ST_START;
            end else if (pop_s) begin
              frame_r <= load_frame_s;
              byte_r  <= '0;
              state_r <= ST_START;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign oTx       = tx_r;
  assign oBusy     = busy_r;
  assign oOverflow = overflow_r;
  assign oLevel    = level_r;

endmodule
